sdram_port_arbiter: RTL

//  Shares the single SDRAM controller between two requesters: the capture write port (current-row

---
 rtl/sdram_port_arbiter.sv | 224 ++++++++++++++++++++++
 1 files changed

// File: rtl/sdram_port_arbiter.sv
// ============================================================================
// Module   : sdram_port_arbiter
// Purpose  : Round-robin burst arbiter between the capture write port and the
//            previous-frame read port, with ping-pong frame-buffer addressing.
//            Optional watchdog: define SDRAM_ARB_WATCHDOG_EN.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module sdram_port_arbiter #(
  parameter int WORD_W      = 16,
  parameter int ADDR_W      = 24,
  parameter int BURST_LEN   = 8,
  parameter int FRAME_WORDS = 196608,
  parameter int TIMEOUT     = 1023
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              i_frame_start,
  input  logic              i_wr_req,
  input  logic [WORD_W-1:0] i_wr_data,
  output logic              o_wr_pop,
  input  logic              i_rd_req,
  output logic [WORD_W-1:0] o_rd_data,
  output logic              o_rd_valid,
  output logic              o_sdram_enable,
  output logic              o_sdram_rw,
  output logic [ADDR_W-1:0] o_sdram_addr,
  output logic [WORD_W-1:0] o_sdram_data,
  input  logic              i_sdram_busy,
  input  logic              i_sdram_valid_wr,
  input  logic              i_sdram_valid_rd,
  input  logic [WORD_W-1:0] i_sdram_data,
  output logic              o_busy,
  output logic              o_error
);

  localparam int PTR_W = $clog2(FRAME_WORDS);
  localparam int CNT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_ISSUE    = 3'd1,
    S_WR_BURST = 3'd2,
    S_RD_BURST = 3'd3,
    S_DRAIN    = 3'd4
  } state_t;

  state_t            state_q;
  logic              buf_sel_q;
  logic              last_grant_q;   // 1 = read port was granted last
  logic              pending_swap_q;
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [PTR_W-1:0]  wr_ptr_d, rd_ptr_d;
  logic [CNT_W-1:0]  beat_q;
  logic              sdram_enable_q;
  logic              sdram_rw_q;
  logic [ADDR_W-1:0] sdram_addr_q;
  logic [WORD_W-1:0] rd_data_q;
  logic              rd_valid_q;

  logic w_wr_beat, w_rd_beat, w_last_beat;
  logic w_pick_rd, w_can_grant, w_swap_now, w_abort;

  function automatic logic [PTR_W-1:0] ptr_adv(input logic [PTR_W-1:0] p);
    logic [PTR_W:0] s;
    s = {1'b0, p} + (PTR_W+1)'(BURST_LEN);
    if (s >= (PTR_W+1)'(FRAME_WORDS))
      return '0;
    return s[PTR_W-1:0];
  endfunction

  function automatic logic [ADDR_W-1:0] mk_addr(input logic b, input logic [PTR_W-1:0] p);
    logic [ADDR_W-1:0] a;
    a             = '0;
    a[PTR_W-1:0]  = p;
    a[ADDR_W-1]   = b;
    return a;
  endfunction

  assign wr_ptr_d    = ptr_adv(wr_ptr_q);
  assign rd_ptr_d    = ptr_adv(rd_ptr_q);
  assign w_wr_beat   = (state_q == S_WR_BURST) && i_sdram_valid_wr;
  assign w_rd_beat   = (state_q == S_RD_BURST) && i_sdram_valid_rd;
  assign w_last_beat = (beat_q == LAST_BEAT);
  // On contention the port that lost last time wins.
  assign w_pick_rd   = i_rd_req && (!i_wr_req || !last_grant_q);
  assign w_can_grant = (i_wr_req || i_rd_req) && !i_sdram_busy && !i_frame_start;
  assign w_swap_now  = pending_swap_q || i_frame_start;

  assign o_wr_pop       = w_wr_beat;
  assign o_sdram_data   = i_wr_data;
  assign o_sdram_enable = sdram_enable_q;
  assign o_sdram_rw     = sdram_rw_q;
  assign o_sdram_addr   = sdram_addr_q;
  assign o_rd_data      = rd_data_q;
  assign o_rd_valid     = rd_valid_q;
  assign o_busy         = (state_q != S_IDLE);

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q        <= S_IDLE;
      buf_sel_q      <= 1'b0;
      last_grant_q   <= 1'b1;
      pending_swap_q <= 1'b0;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      beat_q         <= '0;
      sdram_enable_q <= 1'b0;
      sdram_rw_q     <= 1'b0;
      sdram_addr_q   <= '0;
      rd_data_q      <= '0;
      rd_valid_q     <= 1'b0;
    end else begin
      sdram_enable_q <= 1'b0;
      rd_valid_q     <= w_rd_beat;
      if (w_rd_beat)
        rd_data_q <= i_sdram_data;
      if (i_frame_start && state_q != S_IDLE)
        pending_swap_q <= 1'b1;

      if (w_abort) begin
        // Aborted burst is skipped; a swap queued behind it is not lost.
        state_q <= S_IDLE;
        beat_q  <= '0;
        if (state_q == S_WR_BURST) wr_ptr_q <= wr_ptr_d;
        if (state_q == S_RD_BURST) rd_ptr_q <= rd_ptr_d;
        if (w_swap_now) begin
          buf_sel_q      <= ~buf_sel_q;
          wr_ptr_q       <= '0;
          rd_ptr_q       <= '0;
          pending_swap_q <= 1'b0;
        end
      end else begin
        case (state_q)
          S_IDLE: begin
            if (i_frame_start) begin
              buf_sel_q <= ~buf_sel_q;
              wr_ptr_q  <= '0;
              rd_ptr_q  <= '0;
            end else if (w_can_grant) begin
              state_q        <= S_ISSUE;
              sdram_enable_q <= 1'b1;
              sdram_rw_q     <= w_pick_rd;
              last_grant_q   <= w_pick_rd;
              sdram_addr_q   <= w_pick_rd ? mk_addr(~buf_sel_q, rd_ptr_q)
                                          : mk_addr(buf_sel_q, wr_ptr_q);
              beat_q         <= '0;
            end
          end
          S_ISSUE: state_q <= sdram_rw_q ? S_RD_BURST : S_WR_BURST;
          S_WR_BURST: begin
            if (w_wr_beat) begin
              beat_q <= beat_q + CNT_W'(1);
              if (w_last_beat) begin
                wr_ptr_q <= wr_ptr_d;
                state_q  <= S_DRAIN;
              end
            end
          end
          S_RD_BURST: begin
            if (w_rd_beat) begin
              beat_q <= beat_q + CNT_W'(1);
              if (w_last_beat) begin
                rd_ptr_q <= rd_ptr_d;
                state_q  <= S_DRAIN;
              end
            end
          end
          S_DRAIN: begin
            if (!i_sdram_busy) begin
              state_q <= S_IDLE;
              if (w_swap_now) begin
                buf_sel_q      <= ~buf_sel_q;
                wr_ptr_q       <= '0;
                rd_ptr_q       <= '0;
                pending_swap_q <= 1'b0;
              end
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

`ifdef SDRAM_ARB_WATCHDOG_EN
  localparam int WD_W = $clog2(TIMEOUT + 1);
  logic [WD_W-1:0] wd_cnt_q;
  state_t          wd_state_q;
  logic            error_q;
  logic            w_running;

  assign w_running = (state_q == S_WR_BURST) || (state_q == S_RD_BURST) || (state_q == S_DRAIN);
  assign w_abort   = w_running && !w_wr_beat && !w_rd_beat && (wd_cnt_q == WD_W'(TIMEOUT - 1));
  assign o_error   = error_q;

  // Idle-time counter restarts on every beat and on every state change.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      wd_cnt_q   <= '0;
      wd_state_q <= S_IDLE;
      error_q    <= 1'b0;
    end else begin
      wd_state_q <= state_q;
      error_q    <= w_abort;
      if (!w_running || w_wr_beat || w_rd_beat || w_abort || state_q != wd_state_q)
        wd_cnt_q <= '0;
      else
        wd_cnt_q <= wd_cnt_q + WD_W'(1);
    end
  end
`else
  logic [31:0] unused_timeout;
  assign unused_timeout = 32'(TIMEOUT);
  assign w_abort        = 1'b0;
  assign o_error        = 1'b0;
`endif

endmodule

`default_nettype wire
